jogo_unidade_controle: RTL and testbench
========================================

Name: jogo_unidade_controle

Overview:
Moore-style control unit that sequences the memory-game datapath: address counter, switch register, memory comparator. Waits for each player move (one-cycle jogada pulse from the datapath edge detector), registers it, compares it, and advances through the stored sequence. Ends in a win, error or timeout state. An internal watchdog counter bounds the wait for each move.

Parameters:
TIMEOUT, 3000, max clock cycles spent in espera waiting for jogada before timeout (>=2)

Ports:
clock  input  1  system clock, all state changes on rising edge
reset  input  1  synchronous, active-high; forces inicial on next rising edge
iniciar  input  1  start / restart request, level-sampled
jogada  input  1  one-cycle pulse: player submitted a move
fimC  input  1  address counter at last position
igual  input  1  registered switches equal memory word
zeraC  output  1  clear address counter
contaC  output  1  increment address counter
zeraR  output  1  clear switch register
registraR  output  1  load switch register
pronto  output  1  game finished (any outcome)
acertou  output  1  finished, full sequence correct
errou  output  1  finished, wrong move
timeout  output  1  finished, move not made in time
db_estado  output  4  debug state code

Behaviour:
- Clock is clock. Reset is synchronous and active-high: state <= inicial, watchdog <= 0. Reset wins over every other input, including mid-game and in fim states.
- After reset: zeraC=1, zeraR=1, all other outputs 0, db_estado=0.
- All control outputs are decoded from the current state only (Moore), with no input-to-output paths.
- States, with db_estado code, asserted outputs, and next state:
  - inicial (0): zeraC, zeraR. iniciar -> preparacao, else stay.
  - preparacao (1): zeraC, zeraR -> espera.
  - espera (2): watchdog counts. jogada -> registra. Else watchdog==TIMEOUT-1 -> fim_timeout. Else stay.
  - registra (4): registraR -> comparacao.
  - comparacao (5): !igual -> fim_erro; igual&fimC -> fim_acerto; igual&!fimC -> proximo.
  - proximo (6): contaC -> espera.
  - fim_acerto (A): pronto, acertou. iniciar -> preparacao, else hold.
  - fim_erro (E): pronto, errou. iniciar -> preparacao, else hold.
  - fim_timeout (C): pronto, timeout. iniciar -> preparacao, else hold.
  - any unused encoding: db_estado=F, all outputs 0, next state inicial.
- Watchdog rules:
  - Width is $clog2(TIMEOUT).
  - Cleared in every state other than espera; increments by 1 each cycle in espera.
  - A jogada is accepted in any of the first TIMEOUT cycles of an espera visit.
  - jogada and watchdog==TIMEOUT-1 in the same cycle: jogada wins (-> registra).
  - The watchdog restarts from 0 on every espera entry.
- jogada, iniciar and igual are ignored in states where they are not listed above.
- Outcome flags are mutually exclusive and stay high for as long as the fim state holds.
- Latency per correct move: jogada in espera -> registra (+1) -> comparacao (+2) -> proximo (+3) -> espera (+4).

Optional Feature:
Macro: JOGO_TIMEOUT_EN.
- Defined: watchdog and fim_timeout exist as described above.
- Undefined: no watchdog register; espera waits indefinitely for jogada; timeout output is tied to 0; state code C is treated as an unused encoding.

Test Plan:
- Reset behaviour: assert reset for 1 cycle mid-comparacao -> next edge db_estado=0, zeraC=zeraR=1, pronto=0.
- Full win (TIMEOUT=5, 4-word sequence): iniciar, then 4 jogada pulses with igual=1 and fimC=1 on the 4th -> db_estado 0,1,2,4,5,6,...; contaC pulses exactly 3 times; ends in A with pronto=acertou=1; holds until iniciar.
- Error: igual=0 on the 2nd compare -> db_estado E, errou=1, acertou=0, contaC pulsed once; iniciar -> state 1 next edge.
- Timeout (TIMEOUT=5, macro defined): no jogada after entering espera -> exactly 5 cycles in state 2, then C with timeout=1, pronto=1.
- Timeout boundary: jogada in the 5th espera cycle -> registra (4), no timeout. Next espera visit starts the count from 0.
- Macro undefined: hold espera for 10000 cycles -> stays in 2 with timeout=0; a later jogada proceeds to 4.

Source files
------------

// File: rtl/jogo_unidade_controle.sv
// Moore control unit for the memory game: sequences counter, switch register and comparator.
// Optional JOGO_TIMEOUT_EN adds a per-move watchdog and the fim_timeout end state.
module jogo_unidade_controle #(
   parameter int TIMEOUT = 3000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic       iniciar,
   input  logic       jogada,
   input  logic       fimC,
   input  logic       igual,
   output logic       zeraC,
   output logic       contaC,
   output logic       zeraR,
   output logic       registraR,
   output logic       pronto,
   output logic       acertou,
   output logic       errou,
   output logic       timeout,
   output logic [3:0] db_estado
);

   if (TIMEOUT < 2) begin : g_timeout_check
      $error("jogo_unidade_controle: TIMEOUT must be at least 2");
   end

   typedef enum logic [3:0] {
      inicial     = 4'h0,
      preparacao  = 4'h1,
      espera      = 4'h2,
      registra    = 4'h4,
      comparacao  = 4'h5,
      proximo     = 4'h6,
      fim_acerto  = 4'hA,
`ifdef JOGO_TIMEOUT_EN
      fim_timeout = 4'hC,
`endif
      fim_erro    = 4'hE
   } estado_t;

   estado_t estado, proximo_estado;

   always_ff @(posedge clock) begin
      if (reset) estado <= inicial;
      else       estado <= proximo_estado;
   end

`ifdef JOGO_TIMEOUT_EN
   localparam int WD_W = $clog2(TIMEOUT);
   localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT - 1);

   logic [WD_W-1:0] watchdog;

   // Counts only while in espera, so every espera visit starts again from zero.
   always_ff @(posedge clock) begin
      if (reset)                 watchdog <= '0;
      else if (estado == espera) watchdog <= watchdog + 1'b1;
      else                       watchdog <= '0;
   end
`endif

   always_comb begin
      proximo_estado = estado;
      zeraC          = 1'b0;
      contaC         = 1'b0;
      zeraR          = 1'b0;
      registraR      = 1'b0;
      pronto         = 1'b0;
      acertou        = 1'b0;
      errou          = 1'b0;
      timeout        = 1'b0;
      db_estado      = 4'hF;
      unique case (estado)
         inicial: begin
            zeraC     = 1'b1;
            zeraR     = 1'b1;
            db_estado = 4'h0;
            if (iniciar) proximo_estado = preparacao;
         end
         preparacao: begin
            zeraC          = 1'b1;
            zeraR          = 1'b1;
            db_estado      = 4'h1;
            proximo_estado = espera;
         end
         espera: begin
            db_estado = 4'h2;
            // A move arriving on the last allowed cycle still beats the watchdog.
            if (jogada) proximo_estado = registra;
`ifdef JOGO_TIMEOUT_EN
            else if (watchdog == WD_MAX) proximo_estado = fim_timeout;
`endif
         end
         registra: begin
            registraR      = 1'b1;
            db_estado      = 4'h4;
            proximo_estado = comparacao;
         end
         comparacao: begin
            db_estado = 4'h5;
            if (!igual)     proximo_estado = fim_erro;
            else if (fimC)  proximo_estado = fim_acerto;
            else            proximo_estado = proximo;
         end
         proximo: begin
            contaC         = 1'b1;
            db_estado      = 4'h6;
            proximo_estado = espera;
         end
         fim_acerto: begin
            pronto    = 1'b1;
            acertou   = 1'b1;
            db_estado = 4'hA;
            if (iniciar) proximo_estado = preparacao;
         end
         fim_erro: begin
            pronto    = 1'b1;
            errou     = 1'b1;
            db_estado = 4'hE;
            if (iniciar) proximo_estado = preparacao;
         end
`ifdef JOGO_TIMEOUT_EN
         fim_timeout: begin
            pronto    = 1'b1;
            timeout   = 1'b1;
            db_estado = 4'hC;
            if (iniciar) proximo_estado = preparacao;
         end
`endif
         default: begin
            proximo_estado = inicial;
         end
      endcase
   end

endmodule

// File: tb/tb_jogo_unidade_controle.sv
// Scoreboard bench for jogo_unidade_controle: game-level model pushes expected state per cycle,
// a monitor pops and compares the full output vector.
module tb_jogo_unidade_controle;

   localparam int TIMEOUT = 5;
`ifdef JOGO_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic       clock = 1'b0;
   logic       reset, iniciar, jogada, fimC, igual;
   logic       zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout;
   logic [3:0] db_estado;

   jogo_unidade_controle #(.TIMEOUT(TIMEOUT)) dut (
      .clock(clock), .reset(reset), .iniciar(iniciar), .jogada(jogada),
      .fimC(fimC), .igual(igual), .zeraC(zeraC), .contaC(contaC),
      .zeraR(zeraR), .registraR(registraR), .pronto(pronto),
      .acertou(acertou), .errou(errou), .timeout(timeout), .db_estado(db_estado)
   );

   always #5 clock = ~clock;

   logic [3:0] expq[$];
   logic [3:0] cur;
   int total = 0;
   int bad = 0;
   int cyc = 0;

   // Output vector {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout}
   function automatic logic [11:0] outs(input logic [3:0] s);
      case (s)
         4'h0, 4'h1: return {s, 8'b1010_0000};
         4'h2, 4'h5: return {s, 8'b0000_0000};
         4'h4:       return {s, 8'b0001_0000};
         4'h6:       return {s, 8'b0100_0000};
         4'hA:       return {s, 8'b0000_1100};
         4'hE:       return {s, 8'b0000_1010};
         4'hC:       return {s, 8'b0000_1001};
         default:    return {4'hF, 8'b0000_0000};
      endcase
   endfunction

   function automatic bit rb();
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic step(input bit rst, input bit ini, input bit jog, input bit fc,
                       input bit ig, input logic [3:0] e);
      @(negedge clock);
      reset = rst; iniciar = ini; jogada = jog; fimC = fc; igual = ig;
      expq.push_back(e);
      cur = e;
   endtask

   task automatic hold(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 1'b0, rb(), rb(), rb(), cur);
   endtask

   // One game from inicial or a fim state; gaps[i] = idle espera cycles before move i.
   task automatic play(input int gaps[$], input int bad_at);
      int n;
      n = gaps.size();
      step(1'b0, 1'b1, rb(), rb(), rb(), 4'h1);
      step(1'b0, rb(), rb(), rb(), rb(), 4'h2);
      for (int i = 0; i < n; i++) begin
         for (int k = 0; k < gaps[i]; k++) begin
            if (TO_EN && k == TIMEOUT - 1) begin
               step(1'b0, rb(), 1'b0, rb(), rb(), 4'hC);
               return;
            end
            step(1'b0, rb(), 1'b0, rb(), rb(), 4'h2);
         end
         step(1'b0, rb(), 1'b1, rb(), rb(), 4'h4);
         step(1'b0, rb(), rb(), rb(), rb(), 4'h5);
         if (i == bad_at) begin
            step(1'b0, rb(), rb(), rb(), 1'b0, 4'hE);
            return;
         end
         if (i == n - 1) begin
            step(1'b0, rb(), rb(), 1'b1, 1'b1, 4'hA);
            return;
         end
         step(1'b0, rb(), rb(), 1'b0, 1'b1, 4'h6);
         step(1'b0, rb(), rb(), rb(), rb(), 4'h2);
      end
   endtask

   logic [3:0]  mon_e;
   logic [11:0] mon_got, mon_want;

   initial forever begin
      @(posedge clock);
      #1;
      cyc++;
      if (expq.size() > 0) begin
         mon_e    = expq.pop_front();
         mon_want = outs(mon_e);
         mon_got  = {db_estado, zeraC, contaC, zeraR, registraR, pronto, acertou, errou, timeout};
         total++;
         if (mon_got !== mon_want) begin
            bad++;
            $display("FAIL state_outputs cycle=%0d got=%h expected=%h", cyc, mon_got, mon_want);
         end
      end
   end

   int g[$];
   int n, bad_at, gmax;

   initial begin
      reset = 1'b1; iniciar = 1'b0; jogada = 1'b0; fimC = 1'b0; igual = 1'b0;
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
      hold(3);

      // Full win over a 4-word sequence, then hold in A.
      g.delete(); g.push_back(0); g.push_back(1); g.push_back(2); g.push_back(3);
      play(g, -1);
      hold(4);

      // Error on the second compare, then restart from E.
      g.delete(); g.push_back(1); g.push_back(0); g.push_back(2);
      play(g, 1);
      hold(3);
      g.delete(); g.push_back(0);
      play(g, -1);

      // Reset during comparacao, with iniciar high in the same cycle.
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'h1);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'h2);
      step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 4'h4);
      step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'h5);
      step(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'h0);
      hold(2);

`ifdef JOGO_TIMEOUT_EN
      g.delete(); g.push_back(TIMEOUT + 3);
      play(g, -1);
      hold(3);
      // Move on the last allowed cycle, twice in a row: count restarts on each espera entry.
      g.delete(); g.push_back(TIMEOUT - 1); g.push_back(TIMEOUT - 1); g.push_back(0);
      play(g, -1);
      hold(1);
      g.delete(); g.push_back(0); g.push_back(TIMEOUT);
      play(g, -1);
      hold(2);
`else
      g.delete(); g.push_back(10000); g.push_back(0);
      play(g, -1);
      hold(2);
`endif

      gmax = TO_EN ? TIMEOUT + 1 : 7;
      for (int t = 0; t < 40; t++) begin
         n = $urandom_range(1, 4);
         g.delete();
         for (int i = 0; i < n; i++) g.push_back($urandom_range(0, gmax));
         bad_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, n - 1) : -1;
         play(g, bad_at);
         if ($urandom_range(0, 4) == 0) step(1'b1, rb(), rb(), rb(), rb(), 4'h0);
         hold($urandom_range(0, 2));
      end

      @(negedge clock);
      @(negedge clock);
      total++;
      if (expq.size() != 0) begin
         bad++;
         $display("FAIL scoreboard_drain left=%0d expected=0", expq.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
